// File: rtl/slc3_mem_pkg.sv
// Shared types for the SLC-3 SRAM access path: sequencer states, port indices
// and the request bundle captured at grant time.
package slc3_mem_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
        logic [1:0]             be;
    } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: a tie goes to the port that did not win last.
module rr_arb2
    import slc3_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = PORT_CPU;
        if (req == 2'b11) begin
            grant_idx = ~last_grant;
        end else if (req[1]) begin
            grant_idx = PORT_AUX;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for the shared asynchronous SRAM:
// IDLE -> SETUP -> ACCESS (WAIT_CYCLES+1) -> HOLD, one access at a time.
module sram_arbiter
    import slc3_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [1:0]        be0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [1:0]        be1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ADDR,
    output logic              CE,
    output logic              OE,
    output logic              WE,
    output logic              UB,
    output logic              LB,
    output logic [DATA_W-1:0] Data_out,
    output logic              Data_oe,
    input  logic [DATA_W-1:0] Data_in
);

    state_t            state, state_nxt;
    logic [3:0]        wait_cnt;
    logic              last_grant;
    logic              gnt;
    mem_req_t          cur;
    mem_req_t          sel_req;
    logic [DATA_W-1:0] rdata_q;
    logic              grant_valid;
    logic              grant_idx;

    rr_arb2 u_rr_arb2 (
        .req         ({req1, req0}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        sel_req.we    = we0;
        sel_req.addr  = addr0;
        sel_req.wdata = wdata0;
        sel_req.be    = be0;
        if (grant_idx == PORT_AUX) begin
            sel_req.we    = we1;
            sel_req.addr  = addr1;
            sel_req.wdata = wdata1;
            sel_req.be    = be1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (wait_cnt == 4'd0) state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Requests are latched at grant, so requesters may change fields afterwards.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            last_grant <= PORT_AUX;
            gnt        <= PORT_CPU;
            cur        <= '0;
            rdata_q    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_valid) begin
                gnt        <= grant_idx;
                last_grant <= grant_idx;
                cur        <= sel_req;
            end
            if (state == SETUP) begin
                wait_cnt <= 4'(WAIT_CYCLES);
            end else if (state == ACCESS && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == ACCESS && wait_cnt == 4'd0 && !cur.we) begin
                rdata_q <= Data_in;
            end
        end
    end

    // Strobes decode straight from state so an async reset releases them at once.
    always_comb begin
        CE      = 1'b1;
        OE      = 1'b1;
        WE      = 1'b1;
        UB      = 1'b1;
        LB      = 1'b1;
        Data_oe = 1'b0;
        ack0    = 1'b0;
        ack1    = 1'b0;
        busy    = (state != IDLE);
        if (state != IDLE) begin
            CE      = 1'b0;
            UB      = ~cur.be[1];
            LB      = ~cur.be[0];
            Data_oe = cur.we;
        end
        if (state == ACCESS) begin
            OE = cur.we;
            WE = ~cur.we;
        end
        if (state == HOLD) begin
            ack0 = (gnt == PORT_CPU);
            ack1 = (gnt == PORT_AUX);
        end
    end

    assign ADDR     = cur.addr;
    assign Data_out = cur.wdata;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a WAIT_CYCLES=1 instance on a small SRAM
// model, plus a WAIT_CYCLES=0 instance for the short-access timing.
module tb_sram_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        init_mem;
    logic [15:0] mem [0:255];

    logic        req0, we0, req1, we1;
    logic [19:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic [1:0]  be0, be1;
    logic        ack0, ack1, busy;
    logic [15:0] rdata, Data_out, Data_in;
    logic [19:0] ADDR;
    logic        CE, OE, WE, UB, LB, Data_oe;

    logic        req0_z, we0_z, req1_z, we1_z;
    logic [19:0] addr0_z, addr1_z;
    logic [15:0] wdata0_z, wdata1_z;
    logic [1:0]  be0_z, be1_z;
    logic        ack0_z, ack1_z, busy_z;
    logic [15:0] rdata_z, Data_out_z, Data_in_z;
    logic [19:0] ADDR_z;
    logic        CE_z, OE_z, WE_z, UB_z, LB_z, Data_oe_z;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    sram_arbiter #(.WAIT_CYCLES(1)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .be0(be0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .be1(be1), .ack1(ack1),
        .rdata(rdata), .busy(busy), .ADDR(ADDR), .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB),
        .Data_out(Data_out), .Data_oe(Data_oe), .Data_in(Data_in)
    );

    sram_arbiter #(.WAIT_CYCLES(0)) dut_w0 (
        .Clk(Clk), .Reset(Reset),
        .req0(req0_z), .we0(we0_z), .addr0(addr0_z), .wdata0(wdata0_z), .be0(be0_z), .ack0(ack0_z),
        .req1(req1_z), .we1(we1_z), .addr1(addr1_z), .wdata1(wdata1_z), .be1(be1_z), .ack1(ack1_z),
        .rdata(rdata_z), .busy(busy_z), .ADDR(ADDR_z), .CE(CE_z), .OE(OE_z), .WE(WE_z), .UB(UB_z), .LB(LB_z),
        .Data_out(Data_out_z), .Data_oe(Data_oe_z), .Data_in(Data_in_z)
    );

    // SRAM model: asynchronous read while CE/OE low, byte-masked write while CE/WE low.
    assign Data_in   = (!CE && !OE) ? mem[ADDR[7:0]] : 16'hDEAD;
    assign Data_in_z = (!CE_z && !OE_z) ? mem[ADDR_z[7:0]] : 16'hDEAD;

    always @(posedge Clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'h20] <= 16'h1111;
            mem[8'h21] <= 16'h2222;
            mem[8'h40] <= 16'hA5C3;
        end else if (!CE && !WE) begin
            if (!LB) mem[ADDR[7:0]][7:0]  <= Data_out[7:0];
            if (!UB) mem[ADDR[7:0]][15:8] <= Data_out[15:8];
        end
    end

    task automatic do_req(input bit port, input bit w, input logic [19:0] a,
                          input logic [15:0] d, input logic [1:0] b,
                          output int ack_at, output int we_low, output int oe_low,
                          output int doe_cnt, output int viol, output logic ub_a,
                          output logic lb_a, output logic [15:0] rd, output int wrong_ack);
        ack_at = -1; we_low = 0; oe_low = 0; doe_cnt = 0; viol = 0; wrong_ack = 0;
        ub_a = 1'bx; lb_a = 1'bx; rd = 16'hxxxx;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (!busy) break;
        end
        if (port) begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; be1 = b;
        end else begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; be0 = b;
        end
        @(posedge Clk);
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!WE) we_low++;
            if (!OE) oe_low++;
            if (Data_oe) doe_cnt++;
            if (!OE && !WE) viol++;
            if (Data_oe && !OE) viol++;
            if (!OE || !WE) begin
                ub_a = UB;
                lb_a = LB;
            end
            if (port ? ack0 : ack1) wrong_ack++;
            if (port ? ack1 : ack0) begin
                ack_at = k;
                rd = rdata;
                break;
            end
            @(posedge Clk);
        end
        if (port) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic run_both(output logic [3:0] order, output logic [15:0] rds [4],
                            output int gaps [3], output int n_acks, output int dual);
        int c0, c1, idle;
        logic p;
        c0 = 0; c1 = 0; idle = 0; n_acks = 0; dual = 0; order = 4'bxxxx;
        for (int i = 0; i < 4; i++) rds[i] = 16'hxxxx;
        for (int i = 0; i < 3; i++) gaps[i] = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (!busy) break;
        end
        we0 = 1'b0; addr0 = 20'h00020; be0 = 2'b11; wdata0 = 16'h0;
        we1 = 1'b0; addr1 = 20'h00021; be1 = 2'b11; wdata1 = 16'h0;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(posedge Clk);
            #1;
            if (ack0 && ack1) dual++;
            if (!busy) idle++;
            if (ack0 || ack1) begin
                p = ack1;
                order[n_acks] = p;
                rds[n_acks] = rdata;
                if (n_acks > 0) gaps[n_acks-1] = idle;
                idle = 0;
                n_acks++;
                if (p) begin req1 = 1'b0; c1++; end
                else   begin req0 = 1'b0; c0++; end
            end
            if (n_acks == 4) break;
            @(negedge Clk);
            if (!req0 && c0 < 2) req0 = 1'b1;
            if (!req1 && c1 < 2) req1 = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; init_mem = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; be0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; be1 = '0;
        req0_z = 0; we0_z = 0; addr0_z = '0; wdata0_z = '0; be0_z = '0;
        req1_z = 0; we1_z = 0; addr1_z = '0; wdata1_z = '0; be1_z = '0;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if ({CE, OE, WE, UB, LB} !== 5'b11111) begin
            errors++; $display("FAIL reset_strobes got %b want 11111", {CE, OE, WE, UB, LB});
        end
        checks++;
        if (Data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe got %b want 0", Data_oe); end
        checks++;
        if (ADDR !== 20'h0) begin errors++; $display("FAIL reset_addr got %h want 00000", ADDR); end
        checks++;
        if (Data_out !== 16'h0) begin errors++; $display("FAIL reset_data_out got %h want 0000", Data_out); end
        checks++;
        if (rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h want 0000", rdata); end
        checks++;
        if ({ack0, ack1} !== 2'b00) begin errors++; $display("FAIL reset_ack got %b want 00", {ack0, ack1}); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if ({CE_z, OE_z, WE_z} !== 3'b111) begin
            errors++; $display("FAIL reset_w0_strobes got %b want 111", {CE_z, OE_z, WE_z});
        end
        @(negedge Clk);
        Reset = 1'b1; init_mem = 1'b0;
    endtask

    task automatic test_write();
        int ack_at, we_low, oe_low, doe, viol, wrong;
        logic ub_a, lb_a;
        logic [15:0] rd;
        do_req(1'b0, 1'b1, 20'h00012, 16'hBEEF, 2'b11, ack_at, we_low, oe_low, doe, viol, ub_a, lb_a, rd, wrong);
        checks++;
        if (ack_at !== 3) begin errors++; $display("FAIL write_ack_latency got %0d want 3", ack_at); end
        checks++;
        if (we_low !== 2) begin errors++; $display("FAIL write_we_low got %0d want 2", we_low); end
        checks++;
        if (doe !== 4) begin errors++; $display("FAIL write_data_oe_cycles got %0d want 4", doe); end
        checks++;
        if (oe_low !== 0) begin errors++; $display("FAIL write_oe_low got %0d want 0", oe_low); end
        checks++;
        if ({ub_a, lb_a} !== 2'b00) begin errors++; $display("FAIL write_ub_lb got %b want 00", {ub_a, lb_a}); end
        checks++;
        if (viol !== 0 || wrong !== 0) begin
            errors++; $display("FAIL write_protocol got viol=%0d wrong_ack=%0d want 0/0", viol, wrong);
        end
        checks++;
        if (mem[8'h12] !== 16'hBEEF) begin errors++; $display("FAIL write_mem got %h want beef", mem[8'h12]); end
    endtask

    task automatic test_read();
        int ack_at, we_low, oe_low, doe, viol, wrong;
        logic ub_a, lb_a;
        logic [15:0] rd;
        do_req(1'b0, 1'b0, 20'h00012, 16'h0000, 2'b11, ack_at, we_low, oe_low, doe, viol, ub_a, lb_a, rd, wrong);
        checks++;
        if (rd !== 16'hBEEF) begin errors++; $display("FAIL read_data got %h want beef", rd); end
        checks++;
        if (oe_low !== 2) begin errors++; $display("FAIL read_oe_low got %0d want 2", oe_low); end
        checks++;
        if (we_low !== 0 || doe !== 0) begin
            errors++; $display("FAIL read_we_doe got we_low=%0d doe=%0d want 0/0", we_low, doe);
        end
        checks++;
        if (ack_at !== 3) begin errors++; $display("FAIL read_ack_latency got %0d want 3", ack_at); end
    endtask

    task automatic test_byte_write();
        int ack_at, we_low, oe_low, doe, viol, wrong;
        logic ub_a, lb_a;
        logic [15:0] rd;
        do_req(1'b1, 1'b1, 20'h00012, 16'h1234, 2'b01, ack_at, we_low, oe_low, doe, viol, ub_a, lb_a, rd, wrong);
        checks++;
        if ({ub_a, lb_a} !== 2'b10) begin errors++; $display("FAIL byte_ub_lb got %b want 10", {ub_a, lb_a}); end
        checks++;
        if (ack_at !== 3 || wrong !== 0) begin
            errors++; $display("FAIL byte_ack got at=%0d wrong=%0d want 3/0", ack_at, wrong);
        end
        checks++;
        if (rd !== 16'hBEEF) begin errors++; $display("FAIL byte_rdata_held got %h want beef", rd); end
        checks++;
        if (mem[8'h12] !== 16'hBE34) begin errors++; $display("FAIL byte_mem got %h want be34", mem[8'h12]); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  order;
        logic [15:0] rds [4];
        int gaps [3];
        int n_acks, dual;
        run_both(order, rds, gaps, n_acks, dual);
        checks++;
        if (n_acks !== 4 || order !== 4'b1010) begin
            errors++; $display("FAIL rr_order got n=%0d order=%b want 4 1010", n_acks, order);
        end
        checks++;
        if (dual !== 0) begin errors++; $display("FAIL rr_dual_ack got %0d want 0", dual); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rds[i] !== ((i % 2 == 0) ? 16'h1111 : 16'h2222)) begin
                errors++; $display("FAIL rr_rdata[%0d] got %h want %h", i, rds[i], (i % 2 == 0) ? 16'h1111 : 16'h2222);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (gaps[i] !== 1) begin errors++; $display("FAIL rr_idle_gap[%0d] got %0d want 1", i, gaps[i]); end
        end
    endtask

    task automatic test_byte_readback();
        int ack_at, we_low, oe_low, doe, viol, wrong;
        logic ub_a, lb_a;
        logic [15:0] rd;
        do_req(1'b0, 1'b0, 20'h00012, 16'h0000, 2'b11, ack_at, we_low, oe_low, doe, viol, ub_a, lb_a, rd, wrong);
        checks++;
        if (rd !== 16'hBE34) begin errors++; $display("FAIL readback_data got %h want be34", rd); end
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL readback_protocol got %0d want 0", viol); end
    endtask

    task automatic test_abort();
        int acks_seen;
        logic [3:0]  order;
        logic [15:0] rds [4];
        int gaps [3];
        int n_acks, dual;
        acks_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (!busy) break;
        end
        req0 = 1'b1; we0 = 1'b1; addr0 = 20'h00030; wdata0 = 16'h5555; be0 = 2'b11;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        checks++;
        if (WE !== 1'b0) begin errors++; $display("FAIL abort_in_access got WE=%b want 0", WE); end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if ({CE, OE, WE} !== 3'b111 || Data_oe !== 1'b0) begin
            errors++; $display("FAIL abort_async got CE/OE/WE=%b Data_oe=%b want 111 0", {CE, OE, WE}, Data_oe);
        end
        req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
            if (ack0 || ack1) acks_seen++;
        end
        checks++;
        if (acks_seen !== 0) begin errors++; $display("FAIL abort_no_ack got %0d want 0", acks_seen); end
        @(negedge Clk);
        Reset = 1'b1;
        run_both(order, rds, gaps, n_acks, dual);
        checks++;
        if (n_acks !== 4 || order[0] !== 1'b0) begin
            errors++; $display("FAIL abort_first_grant got n=%0d first=%b want 4 0", n_acks, order[0]);
        end
        checks++;
        if (rds[0] !== 16'h1111) begin errors++; $display("FAIL abort_first_rdata got %h want 1111", rds[0]); end
    endtask

    task automatic test_wait0();
        int ack_at, oe_low;
        logic [15:0] rd;
        ack_at = -1; oe_low = 0; rd = 16'hxxxx;
        @(negedge Clk);
        req0_z = 1'b1; we0_z = 1'b0; addr0_z = 20'h00040; be0_z = 2'b11;
        @(posedge Clk);
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!OE_z) oe_low++;
            if (ack0_z) begin
                ack_at = k;
                rd = rdata_z;
                break;
            end
            @(posedge Clk);
        end
        req0_z = 1'b0;
        checks++;
        if (ack_at !== 2) begin errors++; $display("FAIL w0_ack_latency got %0d want 2", ack_at); end
        checks++;
        if (oe_low !== 1) begin errors++; $display("FAIL w0_oe_low got %0d want 1", oe_low); end
        checks++;
        if (rd !== 16'hA5C3) begin errors++; $display("FAIL w0_rdata got %h want a5c3", rd); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_byte_write();
        test_round_robin();
        test_byte_readback();
        test_abort();
        test_wait0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port arbiter and access sequencer for the shared 16-bit asynchronous SRAM on the SLC-3 board.
- Port 0 is the CPU memory interface (MAR/MDR path). Port 1 is a secondary master (I/O, display or loader).
- Round-robin grant; generates the active-low CE/OE/WE/UB/LB strobes, the 20-bit ADDR, and the data-bus drive enable, with programmable wait states.
- Sits between the CPU/Mem2IO side and the SRAM / test_memory pins, replacing direct CPU strobe generation.

Parameters:
WAIT_CYCLES  1   extra ACCESS cycles beyond the first (legal 0..15)
ADDR_W       20  SRAM address width
DATA_W       16  SRAM data width

Ports:
Clk       in   1       system clock, all state on rising edge
Reset     in   1       asynchronous, active-low reset
req0      in   1       port 0 request; held with fields until ack0
we0       in   1       port 0: 1=write, 0=read
addr0     in   ADDR_W  port 0 address
wdata0    in   DATA_W  port 0 write data
be0       in   2       port 0 byte enables, [1]=upper, [0]=lower
ack0      out  1       one-cycle completion pulse to port 0
req1, we1, addr1, wdata1, be1, ack1: same as port 0, for port 1
rdata     out  DATA_W  read data, valid in the ack cycle (both ports)
busy      out  1       high in SETUP/ACCESS/HOLD
ADDR      out  ADDR_W  SRAM address
CE        out  1       chip enable, active-low
OE        out  1       output enable, active-low
WE        out  1       write enable, active-low
UB        out  1       upper byte enable, active-low
LB        out  1       lower byte enable, active-low
Data_out  out  DATA_W  data to the SRAM bus
Data_oe   out  1       1 = drive Data_out onto the bus (tri-state enable used at top level)
Data_in   in   DATA_W  data from the SRAM bus

Behaviour:
- Reset (Reset=0, async):
  - state=IDLE; CE/OE/WE/UB/LB=1; Data_oe=0.
  - ADDR=0, Data_out=0, rdata=0; ack0/ack1=0; busy=0.
  - last_grant=1, so port 0 wins the first tie.
  - Reset mid-access aborts immediately: strobes deassert in the same instant and no ack is issued.
- States: IDLE, SETUP, ACCESS, HOLD.
- IDLE: all strobes high.
  - Requests are sampled on each edge. If only one is high, grant it. If both are high, grant the port not equal to last_grant.
  - On grant: latch g, we, addr, wdata, be into internal registers; set last_grant=g; go to SETUP.
- SETUP (1 cycle): ADDR=latched addr; CE=0; UB=~be[1]; LB=~be[0]; OE=WE=1. On writes, Data_oe=1 with Data_out=wdata.
- ACCESS (WAIT_CYCLES+1 cycles, counted by a 4-bit down-counter):
  - Read: OE=0.
  - Write: WE=0, Data_oe=1.
  - Read data: rdata captures Data_in on the final ACCESS edge.
- HOLD (1 cycle): OE=WE=1; CE and ADDR held; on writes Data_oe stays 1 (data hold). ack[g]=1 for exactly this cycle. Next state is always IDLE.
- Latency: request sampled at edge t0 gives ack high during cycle t0+WAIT_CYCLES+3. Minimum one IDLE cycle between consecutive accesses.
- Requesters must hold all fields until ack. Latched copies are used, so field changes after grant do not affect the access.
- req deasserted before grant: no access. req deasserted after grant: the access completes and ack still pulses.
- be=2'b00 still runs the full cycle with UB=LB=1 (a no-op access), and ack pulses.
- OE and WE are never low simultaneously. Data_oe is never 1 while OE=0.
- rdata holds its value until the next read completes; writes do not modify it.

Decomposition:
- Package slc3_mem_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, HOLD);
  - port index constants PORT_CPU=0, PORT_AUX=1;
  - a struct bundling {we, addr, wdata, be} for the latched request.
- Sub-module rr_arb2: combinational two-requester round-robin picker.
  - Inputs: req[1:0], last_grant. Outputs: grant_valid, grant_idx.
- Sequencing, counter and strobes stay in sram_arbiter.

Test Plan:
- Reset, then WAIT_CYCLES=1. Port 0 writes addr0=0x00012, wdata0=0xBEEF, be0=2'b11. Required: WE low for exactly 2 cycles; Data_oe high from SETUP through HOLD; ack0 at t0+4.
- Port 0 then reads 0x00012 from the test memory model. Required: OE low for 2 cycles; rdata=0xBEEF with ack0; WE stays high throughout.
- req0 and req1 asserted together continuously, each dropped after its ack. Required: grant order 0,1,0,1; each ack lands on its own port; one IDLE cycle between accesses.
- Byte write with be1=2'b01, wdata1=0x1234 to a word holding 0xBEEF. Required: UB=1, LB=0 during the access; a later read returns 0xBE34.
- Reset pulled low during ACCESS. Required: CE/OE/WE go high asynchronously, Data_oe=0, no ack; after release, the first request (on either port) is serviced normally.
- WAIT_CYCLES=0 build, single read. Required: OE low for 1 cycle; ack at t0+3.
